// File: rtl/memmap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : memmap_pkg
//  Description : Region encoding, default map constants and the address
//                decoder shared by the Hack-style data-memory map.
//  Revision    : 1.0 - initial release
// ============================================================================
package memmap_pkg;

    // Default map; the top module re-exports these as overridable parameters.
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_ADDR_W    = 15;
    localparam int unsigned DEF_RAM_DEPTH = 16384;
    localparam int unsigned DEF_SCR_BASE  = 16384;
    localparam int unsigned DEF_SCR_DEPTH = 8192;
    localparam int unsigned DEF_KBD_ADDR  = 24576;
    localparam int unsigned DEF_KBD_DEPTH = 4;

    typedef enum logic [2:0] {
        RGN_RAM  = 3'd0,
        RGN_SCR  = 3'd1,
        RGN_KBD  = 3'd2,
        RGN_STAT = 3'd3,
        RGN_NONE = 3'd4
    } region_e;

    // Bounds are tested on full-width integers so no offset can wrap.
    function automatic region_e decode_region(
        input int unsigned addr,
        input int unsigned ram_depth,
        input int unsigned scr_base,
        input int unsigned scr_depth,
        input int unsigned kbd_addr
    );
        region_e rgn;
        rgn = RGN_NONE;
        if (addr < ram_depth) begin
            rgn = RGN_RAM;
        end else if ((addr >= scr_base) && (addr < (scr_base + scr_depth))) begin
            rgn = RGN_SCR;
        end else if (addr == kbd_addr) begin
            rgn = RGN_KBD;
        end else if (addr == (kbd_addr + 1)) begin
            rgn = RGN_STAT;
        end
        return rgn;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : kbd_fifo
//  Description : Small synchronous FIFO buffering keyboard codes. Push is
//                refused when full, pop is ignored when empty, and a push and
//                pop in the same cycle leave the occupancy unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module kbd_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DATA_W-1:0]          i_push_data,
    input  logic                       i_pop,
    output logic [DATA_W-1:0]          o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    // Guard both operations internally so callers cannot corrupt the pointers.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/memory_map_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : memory_map_ctrl
//  Description : Data-memory map for the Hack-style CPU. Decodes the CPU word
//                address into general RAM, screen RAM, keyboard FIFO and a
//                status register; registered read-first reads, a second
//                screen read port for the display and a sticky bus error.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_map_ctrl
    import memmap_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int unsigned SCR_BASE  = DEF_SCR_BASE,
    parameter int unsigned SCR_DEPTH = DEF_SCR_DEPTH,
    parameter int unsigned KBD_ADDR  = DEF_KBD_ADDR,
    parameter int unsigned KBD_DEPTH = DEF_KBD_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            in,
    input  logic [ADDR_W-1:0]            address,
    input  logic                         load,
    output logic [DATA_W-1:0]            out,
    input  logic [$clog2(SCR_DEPTH)-1:0] scr_addr,
    output logic [DATA_W-1:0]            scr_data,
    input  logic [DATA_W-1:0]            kbd_data,
    input  logic                         kbd_valid,
    output logic                         kbd_ready,
    output logic                         bus_err
);

    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
    localparam int unsigned SCR_AW = $clog2(SCR_DEPTH);
    localparam int unsigned CNT_W  = $clog2(KBD_DEPTH+1);

    region_e           w_region;
    region_e           r_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [SCR_AW-1:0] w_scr_off;
    logic              w_ram_we;
    logic              w_scr_we;
    logic              w_kbd_pop;
    logic              w_stat_clr;
    logic              w_unmapped;

    logic [DATA_W-1:0] r_ram [RAM_DEPTH];
    logic [DATA_W-1:0] r_scr [SCR_DEPTH];
    logic [DATA_W-1:0] r_ram_rd;
    logic [DATA_W-1:0] r_scr_rd;
    logic [DATA_W-1:0] r_scr_disp;
    logic [DATA_W-1:0] w_io_rd;
    logic [DATA_W-1:0] r_io_rd;
    logic              r_bus_err;

    logic [DATA_W-1:0] w_fifo_head;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    // Region decode is purely combinational on the CPU address.
    assign w_region   = decode_region(32'(address), RAM_DEPTH, SCR_BASE, SCR_DEPTH, KBD_ADDR);
    assign w_ram_idx  = RAM_AW'(address);
    assign w_scr_off  = SCR_AW'(address - ADDR_W'(SCR_BASE));
    assign w_ram_we   = load && (w_region == RGN_RAM);
    assign w_scr_we   = load && (w_region == RGN_SCR);
    assign w_kbd_pop  = load && (w_region == RGN_KBD);
    assign w_stat_clr = load && (w_region == RGN_STAT);
    assign w_unmapped = (w_region == RGN_NONE);

    assign kbd_ready  = !w_fifo_full;
    assign bus_err    = r_bus_err;
    assign scr_data   = r_scr_disp;

    kbd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (KBD_DEPTH)
    ) u_kbd_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (kbd_valid),
        .i_push_data (kbd_data),
        .i_pop       (w_kbd_pop),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // General RAM: single port, read-first so a write returns the old word.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_idx] <= in;
        end
        r_ram_rd <= r_ram[w_ram_idx];
    end

    // Screen RAM CPU port: write plus read-first read.
    always_ff @(posedge clk) begin
        if (w_scr_we) begin
            r_scr[w_scr_off] <= in;
        end
        r_scr_rd <= r_scr[w_scr_off];
    end

    // Screen RAM display port: read-only, sees the pre-write word on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scr_disp <= '0;
        end else begin
            r_scr_disp <= r_scr[scr_addr];
        end
    end

    // Keyboard head (zero when empty) or status word, selected by region.
    always_comb begin
        w_io_rd = '0;
        if (w_region == RGN_KBD) begin
            w_io_rd = w_fifo_empty ? '0 : w_fifo_head;
        end else if (w_region == RGN_STAT) begin
            w_io_rd = DATA_W'({w_fifo_count, r_bus_err});
        end
    end

    // Region select and I/O read data are registered to line up with array reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_region <= RGN_NONE;
            r_io_rd  <= '0;
        end else begin
            r_region <= w_region;
            r_io_rd  <= w_io_rd;
        end
    end

    // Sticky error: set by any unmapped access, cleared by a status write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bus_err <= 1'b0;
        end else if (w_unmapped) begin
            r_bus_err <= 1'b1;
        end else if (w_stat_clr) begin
            r_bus_err <= 1'b0;
        end
    end

    // Output mux; resetting the region select to NONE forces out to zero at once.
    always_comb begin
        out = '0;
        case (r_region)
            RGN_RAM:  out = r_ram_rd;
            RGN_SCR:  out = r_scr_rd;
            RGN_KBD:  out = r_io_rd;
            RGN_STAT: out = r_io_rd;
            default:  out = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_map_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_map_ctrl
//  Description : Self-checking bench for memory_map_ctrl. A behavioural model
//                (associative arrays, a queue and a flag) predicts every
//                output each cycle; directed vectors add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_map_ctrl;

    localparam int RAM_DEPTH = 16384;
    localparam int SCR_BASE  = 16384;
    localparam int SCR_DEPTH = 8192;
    localparam int KBD_ADDR  = 24576;
    localparam int KBD_DEPTH = 4;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic [15:0] d_in      = '0;
    logic [14:0] address   = 15'h0010;
    logic        load      = 1'b0;
    logic [15:0] d_out;
    logic [12:0] scr_addr  = '0;
    logic [15:0] scr_data;
    logic [15:0] kbd_data  = '0;
    logic        kbd_valid = 1'b0;
    logic        kbd_ready;
    logic        bus_err;

    memory_map_ctrl #(
        .DATA_W    (16),
        .ADDR_W    (15),
        .RAM_DEPTH (RAM_DEPTH),
        .SCR_BASE  (SCR_BASE),
        .SCR_DEPTH (SCR_DEPTH),
        .KBD_ADDR  (KBD_ADDR),
        .KBD_DEPTH (KBD_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (d_in),
        .address   (address),
        .load      (load),
        .out       (d_out),
        .scr_addr  (scr_addr),
        .scr_data  (scr_data),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    logic [15:0] ram_m [int];
    logic [15:0] scr_m [int];
    logic [15:0] kq [$];
    bit          berr_m        = 1'b0;
    bit          exp_out_known = 1'b1;
    logic [15:0] exp_out       = '0;
    bit          exp_scr_known = 1'b1;
    logic [15:0] exp_scr       = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit is_ram(input int a);  return a < RAM_DEPTH; endfunction
    function automatic bit is_scr(input int a);  return (a >= SCR_BASE) && (a < SCR_BASE + SCR_DEPTH); endfunction
    function automatic bit is_kbd(input int a);  return a == KBD_ADDR; endfunction
    function automatic bit is_stat(input int a); return a == KBD_ADDR + 1; endfunction

    // Behavioural model: predict this edge's read results from pre-edge state, then apply effects.
    always @(posedge clk or posedge reset) begin
        int a;
        int sa;
        bit do_push;
        bit do_pop;
        if (reset) begin
            kq.delete();
            ram_m.delete();
            scr_m.delete();
            berr_m        = 1'b0;
            exp_out       = '0;
            exp_out_known = 1'b1;
            exp_scr       = '0;
            exp_scr_known = 1'b1;
        end else begin
            a  = address;
            sa = scr_addr;
            exp_out_known = 1'b1;
            exp_out       = '0;
            if (is_ram(a)) begin
                if (ram_m.exists(a)) exp_out = ram_m[a];
                else exp_out_known = 1'b0;
            end else if (is_scr(a)) begin
                if (scr_m.exists(a - SCR_BASE)) exp_out = scr_m[a - SCR_BASE];
                else exp_out_known = 1'b0;
            end else if (is_kbd(a)) begin
                exp_out = (kq.size() > 0) ? kq[0] : 16'h0;
            end else if (is_stat(a)) begin
                exp_out = 16'(kq.size() * 2 + (berr_m ? 1 : 0));
            end
            exp_scr_known = scr_m.exists(sa);
            exp_scr       = exp_scr_known ? scr_m[sa] : 16'h0;

            do_push = kbd_valid && (kq.size() < KBD_DEPTH);
            do_pop  = load && is_kbd(a) && (kq.size() > 0);
            if (load && is_ram(a))  ram_m[a] = d_in;
            if (load && is_scr(a))  scr_m[a - SCR_BASE] = d_in;
            if (load && is_stat(a)) berr_m = 1'b0;
            if (!(is_ram(a) || is_scr(a) || is_kbd(a) || is_stat(a))) berr_m = 1'b1;
            if (do_pop) void'(kq.pop_front());
            if (do_push) kq.push_back(kbd_data);
        end
    end

    // Compare every cycle on the falling edge, skipping words whose contents are undefined.
    always @(negedge clk) begin
        if (exp_out_known) chk("out", d_out, exp_out);
        if (exp_scr_known) chk("scr_data", scr_data, exp_scr);
        chk("kbd_ready", kbd_ready, kq.size() < KBD_DEPTH);
        chk("bus_err", bus_err, berr_m);
    end

    task automatic step(input logic [14:0] a, input logic [15:0] d, input logic ld,
                        input logic [12:0] sa, input logic kv, input logic [15:0] kd);
        address   = a;
        d_in      = d;
        load      = ld;
        scr_addr  = sa;
        kbd_valid = kv;
        kbd_data  = kd;
        @(negedge clk);
    endtask

    task automatic rd(input logic [14:0] a);
        step(a, 16'h0, 1'b0, 13'h0, 1'b0, 16'h0);
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        step(a, d, 1'b1, 13'h0, 1'b0, 16'h0);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out", d_out, 16'h0);
        chk("rst_scr_data", scr_data, 16'h0);
        chk("rst_kbd_ready", kbd_ready, 1'b1);
        chk("rst_bus_err", bus_err, 1'b0);
        reset = 1'b0;

        // RAM write then read, read-during-write returns old word
        wr(15'h0010, 16'h1234);
        rd(15'h0010);
        chk("t1_read", d_out, 16'h1234);
        wr(15'h0010, 16'h5678);
        chk("t1_rdw_old", d_out, 16'h1234);
        rd(15'h0010);
        chk("t1_rdw_new", d_out, 16'h5678);
        wr(15'h3FFF, 16'hC0DE);
        rd(15'h3FFF);
        chk("ram_top", d_out, 16'hC0DE);
        chk("ram_top_berr", bus_err, 1'b0);

        // Screen: display port collides with CPU write
        wr(15'h4005, 16'h1111);
        step(15'h4005, 16'hAAAA, 1'b1, 13'd5, 1'b0, 16'h0);
        chk("t2_scr_old", scr_data, 16'h1111);
        chk("t2_out_old", d_out, 16'h1111);
        step(15'h4005, 16'h0, 1'b0, 13'd5, 1'b0, 16'h0);
        chk("t2_scr_new", scr_data, 16'hAAAA);
        chk("t2_out_new", d_out, 16'hAAAA);
        wr(15'h5FFF, 16'hBEEF);
        step(15'h0010, 16'h0, 1'b0, 13'h1FFF, 1'b0, 16'h0);
        chk("scr_top", scr_data, 16'hBEEF);

        // Keyboard fill to full, held valid, pop
        for (int i = 0; i < 4; i++) step(15'h0010, 16'h0, 1'b0, 13'h0, 1'b1, 16'(16'h41 + i));
        chk("t3_full_ready", kbd_ready, 1'b0);
        step(15'h0010, 16'h0, 1'b0, 13'h0, 1'b1, 16'h45);
        step(15'h6000, 16'h0, 1'b0, 13'h0, 1'b1, 16'h45);
        chk("t3_head", d_out, 16'h0041);
        chk("t3_still_full", kbd_ready, 1'b0);
        wr(15'h6000, 16'hFFFF);
        chk("t3_ready_after_pop", kbd_ready, 1'b1);
        rd(15'h6000);
        chk("t3_next_head", d_out, 16'h0042);
        rd(15'h6001);
        chk("t3_status", d_out, 16'h0006);
        repeat (3) wr(15'h6000, 16'h0);
        rd(15'h6001);
        chk("drain_status", d_out, 16'h0000);

        // Empty FIFO read, pop+push same cycle
        rd(15'h6000);
        chk("t4_empty_read", d_out, 16'h0000);
        step(15'h6000, 16'h0, 1'b1, 13'h0, 1'b1, 16'h55);
        rd(15'h6001);
        chk("t4_count", d_out, 16'h0002);
        rd(15'h6000);
        chk("t4_head", d_out, 16'h0055);
        step(15'h6000, 16'h0, 1'b1, 13'h0, 1'b1, 16'h66);
        rd(15'h6001);
        chk("pushpop_count", d_out, 16'h0002);
        rd(15'h6000);
        chk("pushpop_head", d_out, 16'h0066);

        // Unmapped access and bus error clear
        rd(15'h6005);
        chk("t5_unmapped_out", d_out, 16'h0000);
        chk("t5_berr_set", bus_err, 1'b1);
        rd(15'h6001);
        chk("t5_status", d_out, 16'h0003);
        wr(15'h6001, 16'hFFFF);
        chk("t5_berr_clr", bus_err, 1'b0);
        wr(15'h7000, 16'h9999);
        chk("unmapped_write_berr", bus_err, 1'b1);
        wr(15'h6001, 16'h0);
        rd(15'h0010);
        chk("ram_intact", d_out, 16'h5678);

        // Asynchronous reset with keys queued and error set
        rd(15'h7FFF);
        step(15'h0010, 16'h0, 1'b0, 13'h0, 1'b1, 16'h77);
        rd(15'h0010);
        chk("t6_pre_berr", bus_err, 1'b1);
        chk("t6_pre_ready", kbd_ready, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t6_out", d_out, 16'h0);
        chk("t6_berr", bus_err, 1'b0);
        chk("t6_ready", kbd_ready, 1'b1);
        chk("t6_scr_data", scr_data, 16'h0);
        @(negedge clk);
        reset = 1'b0;
        rd(15'h6001);
        chk("t6_status", d_out, 16'h0000);
        rd(15'h6000);
        chk("t6_kbd_empty", d_out, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
